// File: rtl/riscv_hwloop_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_hwloop_pkg: shared types and write-enable indices for the    |
// | hardware-loop register file.            Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_hwloop_pkg;
  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  typedef logic [31:0] hwlp_addr_t;
  typedef logic [31:0] hwlp_cnt_t;
endpackage

`default_nettype wire

// File: rtl/riscv_hwloop_slot.sv
// +--------------------------------------------------------------------+
// | riscv_hwloop_slot: start/end/counter storage, in-flight decrement  |
// | flag and saturating decrement for one hardware loop.               |
// | Optional: RISCV_HWLOOP_PERF_CNT_EN adds an applied-decrement count.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_hwloop_slot
  import riscv_hwloop_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_we,
  input  logic       end_we,
  input  logic       cnt_we,
  input  hwlp_addr_t start_data,
  input  hwlp_addr_t end_data,
  input  hwlp_cnt_t  cnt_data,
  input  logic       dec_req,
  input  logic       id_valid,
  input  logic       id_flush,
  output hwlp_addr_t start_addr,
  output hwlp_addr_t end_addr,
  output hwlp_cnt_t  counter,
`ifdef RISCV_HWLOOP_PERF_CNT_EN
  output hwlp_cnt_t  iter_cnt,
`endif
  output logic       pend
);

  logic w_retire;
  logic w_apply;
  logic w_pend_nxt;

  // The end-of-loop instruction leaves ID unkilled: the decrement commits.
  assign w_retire = pend & id_valid & ~id_flush;
  assign w_apply  = w_retire & (counter != '0);

  always_comb begin
    w_pend_nxt = pend;
    if (cnt_we)
      w_pend_nxt = 1'b0;
    else if (!pend)
      w_pend_nxt = dec_req;
    else if (id_flush)
      w_pend_nxt = 1'b0;
    else if (id_valid)
      w_pend_nxt = dec_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_addr <= '0;
      end_addr   <= '0;
      counter    <= '0;
      pend       <= 1'b0;
    end else begin
      pend <= w_pend_nxt;
      if (start_we)
        start_addr <= start_data;
      if (end_we)
        end_addr <= end_data;
      if (cnt_we)
        counter <= cnt_data;
      else if (w_apply)
        counter <= counter - 32'd1;
    end
  end

`ifdef RISCV_HWLOOP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      iter_cnt <= '0;
    else if (cnt_we)
      iter_cnt <= '0;
    else if (w_apply)
      iter_cnt <= iter_cnt + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/riscv_hwloop_regfile.sv
// +--------------------------------------------------------------------+
// | riscv_hwloop_regfile: hardware-loop register file, N_REGS slots.   |
// | Optional: RISCV_HWLOOP_PERF_CNT_EN adds hwlp_iter_cnt_o.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_hwloop_regfile
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  hwlp_addr_t                    hwlp_start_data_i,
  input  hwlp_addr_t                    hwlp_end_data_i,
  input  hwlp_cnt_t                     hwlp_cnt_data_i,
  input  logic [2:0]                    hwlp_we_i,
  input  logic [N_REG_BITS-1:0]         hwlp_regid_i,
  input  logic [N_REGS-1:0]             hwlp_dec_cnt_i,
  input  logic                          id_valid_i,
  input  logic                          id_flush_i,
  output hwlp_addr_t [N_REGS-1:0]       hwlp_start_addr_o,
  output hwlp_addr_t [N_REGS-1:0]       hwlp_end_addr_o,
  output hwlp_cnt_t  [N_REGS-1:0]       hwlp_counter_o,
`ifdef RISCV_HWLOOP_PERF_CNT_EN
  output hwlp_cnt_t  [N_REGS-1:0]       hwlp_iter_cnt_o,
`endif
  output logic [N_REGS-1:0]             hwlp_dec_cnt_id_o
);

  for (genvar k = 0; k < N_REGS; k++) begin : g_slot
    // Indices >= N_REGS never match any slot, so such writes are dropped.
    logic w_sel;
    assign w_sel = (32'(hwlp_regid_i) == 32'(k));

    riscv_hwloop_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_we   (w_sel & hwlp_we_i[HWLP_WE_START]),
      .end_we     (w_sel & hwlp_we_i[HWLP_WE_END]),
      .cnt_we     (w_sel & hwlp_we_i[HWLP_WE_CNT]),
      .start_data (hwlp_start_data_i),
      .end_data   (hwlp_end_data_i),
      .cnt_data   (hwlp_cnt_data_i),
      .dec_req    (hwlp_dec_cnt_i[k]),
      .id_valid   (id_valid_i),
      .id_flush   (id_flush_i),
      .start_addr (hwlp_start_addr_o[k]),
      .end_addr   (hwlp_end_addr_o[k]),
      .counter    (hwlp_counter_o[k]),
`ifdef RISCV_HWLOOP_PERF_CNT_EN
      .iter_cnt   (hwlp_iter_cnt_o[k]),
`endif
      .pend       (hwlp_dec_cnt_id_o[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_hwloop_regfile.sv
// +--------------------------------------------------------------------+
// | tb_riscv_hwloop_regfile: directed self-checking bench.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_riscv_hwloop_regfile;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       start_d, end_d, cnt_d;
  logic [2:0]        we;
  logic [0:0]        regid;
  logic [1:0]        dec;
  logic              valid, flush;
  logic [1:0][31:0]  start_a, end_a, cntr;
  logic [1:0]        pend;
`ifdef RISCV_HWLOOP_PERF_CNT_EN
  logic [1:0][31:0]  iter;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_hwloop_regfile #(.N_REGS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hwlp_start_data_i (start_d),
    .hwlp_end_data_i   (end_d),
    .hwlp_cnt_data_i   (cnt_d),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .hwlp_dec_cnt_i    (dec),
    .id_valid_i        (valid),
    .id_flush_i        (flush),
    .hwlp_start_addr_o (start_a),
    .hwlp_end_addr_o   (end_a),
    .hwlp_counter_o    (cntr),
`ifdef RISCV_HWLOOP_PERF_CNT_EN
    .hwlp_iter_cnt_o   (iter),
`endif
    .hwlp_dec_cnt_id_o (pend)
  );

  // Stimulus must never issue a new request to a pending loop without retire/flush.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (pend & dec) != 2'b00 && !valid && !flush) begin
      total++; bad++;
      $display("FAIL dropped_request pend=%b dec=%b", pend, dec);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clr_in;
    we = 3'b000; regid = 1'b0; start_d = '0; end_d = '0; cnt_d = '0;
    dec = 2'b00; valid = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input logic id, input logic [2:0] w, input logic [31:0] s,
                    input logic [31:0] e, input logic [31:0] c);
    regid = id; we = w; start_d = s; end_d = e; cnt_d = c;
    tick();
    clr_in();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; we = 3'b111; start_d = 32'hdead; end_d = 32'hbeef; cnt_d = 32'h7;
    dec = 2'b11; valid = 1'b1; regid = 1'b1; flush = 1'b0;
    tick(); tick();
    clr_in(); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (start_a[k] !== 32'h0) begin bad++; $display("FAIL reset_start%0d actual=%h required=0", k, start_a[k]); end
      if (end_a[k] !== 32'h0) begin bad++; $display("FAIL reset_end%0d actual=%h required=0", k, end_a[k]); end
      if (cntr[k] !== 32'h0) begin bad++; $display("FAIL reset_cnt%0d actual=%h required=0", k, cntr[k]); end
      total += 3;
    end
    chk("reset_pend", {30'b0, pend}, 32'h0);
  endtask

  task automatic test_write;
    wr(1'b1, 3'b111, 32'h100, 32'h120, 32'd3);
    chk("wr_start1", start_a[1], 32'h100);
    chk("wr_end1", end_a[1], 32'h120);
    chk("wr_cnt1", cntr[1], 32'd3);
    chk("wr_start0", start_a[0], 32'h0);
    chk("wr_cnt0", cntr[0], 32'h0);
    wr(1'b0, 3'b010, 32'h55, 32'h123, 32'h9);
    chk("wr_end_unaligned", end_a[0], 32'h123);
    chk("wr_start_not_enabled", start_a[0], 32'h0);
    chk("wr_cnt_not_enabled", cntr[0], 32'h0);
  endtask

  task automatic test_decrement;
    wr(1'b0, 3'b100, 0, 0, 32'd3);
    dec = 2'b01; tick(); dec = 2'b00;
    chk("dec_pend_set", {30'b0, pend}, 32'h1);
    chk("dec_cnt_held", cntr[0], 32'd3);
    valid = 1'b1; tick(); valid = 1'b0;
    chk("dec_pend_clr", {30'b0, pend}, 32'h0);
    chk("dec_cnt_2", cntr[0], 32'd2);
    valid = 1'b1; tick(); valid = 1'b0;
    chk("dec_no_extra", cntr[0], 32'd2);
  endtask

  task automatic test_flush;
    dec = 2'b01; tick(); dec = 2'b00;
    wr(1'b0, 3'b001, 32'h200, 0, 0);
    chk("flush_start_keeps_pend", {30'b0, pend}, 32'h1);
    chk("flush_start_written", start_a[0], 32'h200);
    valid = 1'b1; flush = 1'b1; tick(); valid = 1'b0; flush = 1'b0;
    chk("flush_pend_clr", {30'b0, pend}, 32'h0);
    chk("flush_cnt_kept", cntr[0], 32'd2);
  endtask

  task automatic test_saturate;
    wr(1'b0, 3'b100, 0, 0, 32'd1);
    dec = 2'b01; tick(); dec = 2'b00; valid = 1'b1; tick(); valid = 1'b0;
    chk("sat_to_zero", cntr[0], 32'd0);
    dec = 2'b01; tick(); dec = 2'b00; valid = 1'b1; tick(); valid = 1'b0;
    chk("sat_no_wrap", cntr[0], 32'd0);
`ifdef RISCV_HWLOOP_PERF_CNT_EN
    chk("sat_iter", iter[0], 32'd1);
`endif
  endtask

  task automatic test_write_wins;
    wr(1'b0, 3'b100, 0, 0, 32'd4);
    dec = 2'b01; tick(); dec = 2'b00;
    valid = 1'b1; regid = 1'b0; we = 3'b100; cnt_d = 32'd10;
    tick(); clr_in();
    chk("ww_cnt", cntr[0], 32'd10);
    chk("ww_pend", {30'b0, pend}, 32'h0);
`ifdef RISCV_HWLOOP_PERF_CNT_EN
    chk("ww_iter", iter[0], 32'd0);
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_c [4];
    exp_c[0] = 32'd5; exp_c[1] = 32'd4; exp_c[2] = 32'd3; exp_c[3] = 32'd2;
    wr(1'b0, 3'b100, 0, 0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      dec = 2'b01; valid = 1'b1; tick();
      chk($sformatf("b2b_cnt%0d", i), cntr[0], exp_c[i]);
      chk($sformatf("b2b_pend%0d", i), {30'b0, pend}, 32'h1);
    end
    dec = 2'b00; valid = 1'b1; tick(); valid = 1'b0;
    chk("b2b_cnt_last", cntr[0], 32'd1);
    chk("b2b_pend_last", {30'b0, pend}, 32'h0);
`ifdef RISCV_HWLOOP_PERF_CNT_EN
    chk("b2b_iter", iter[0], 32'd4);
`endif
  endtask

  task automatic test_independent;
    dec = 2'b11; tick(); dec = 2'b00;
    chk("ind_pend_both", {30'b0, pend}, 32'h3);
    valid = 1'b1; tick(); valid = 1'b0;
    chk("ind_cnt0", cntr[0], 32'd0);
    chk("ind_cnt1", cntr[1], 32'd2);
  endtask

  task automatic test_reset_pending;
    dec = 2'b10; tick(); dec = 2'b00;
    chk("rp_pend_set", {30'b0, pend}, 32'h2);
    rst_n = 1'b0; valid = 1'b1; tick(); rst_n = 1'b1; valid = 1'b0;
    chk("rp_pend", {30'b0, pend}, 32'h0);
    chk("rp_cnt1", cntr[1], 32'd0);
  endtask

  initial begin
    clr_in(); rst_n = 1'b0;
    test_reset();
    test_write();
    test_decrement();
    test_flush();
    test_saturate();
    test_write_wins();
    test_back_to_back();
    test_independent();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
